pps_divider_bank: RTL and testbench

Parametrised N-channel PPS divider/phase-shifter that sits between the PPS input conditioning and the channel output mux. Each channel emits a pulse every D-th PPS edge, delayed by a programmable phase in clock cycles and held high for a programmable width. Channels can run periodically or one-shot and report a sticky overrun flag. Configuration is latched per channel on start, so register writes made while a channel runs have no effect on it.

---
 rtl/pps_divider_bank_if.sv | 29 ++
 rtl/pps_divider_bank.sv | 148 ++++++++++++++
 tb/tb_pps_divider_bank.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pps_divider_bank_if.sv
// Signal bundle between PPS conditioning/config registers and pps_divider_bank.
// The master drives the config and strobes; the slave (the divider bank) drives the status.
interface pps_divider_bank_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 8,
    parameter int PH_W  = 32,
    parameter int WD_W  = 8
);
    logic                  i_pps;
    logic [N_CH-1:0]       i_start;
    logic [N_CH-1:0]       i_stop;
    logic [N_CH-1:0]       i_per_true;
    logic [N_CH*DIV_W-1:0] i_div_num;
    logic [N_CH*PH_W-1:0]  i_phase;
    logic [N_CH*WD_W-1:0]  i_width;
    logic [N_CH-1:0]       o_pps_div;
    logic [N_CH-1:0]       o_busy;
    logic [N_CH-1:0]       o_overrun;

    modport master (
        output i_pps, i_start, i_stop, i_per_true, i_div_num, i_phase, i_width,
        input  o_pps_div, o_busy, o_overrun
    );

    modport slave (
        input  i_pps, i_start, i_stop, i_per_true, i_div_num, i_phase, i_width,
        output o_pps_div, o_busy, o_overrun
    );
endinterface

// File: rtl/pps_divider_bank.sv
// N-channel PPS divider / phase shifter: each channel pulses every D-th PPS edge,
// delayed by P cycles and held for W cycles, periodic or one-shot, with sticky overrun.
module pps_divider_bank #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 8,
    parameter int PH_W  = 32,
    parameter int WD_W  = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    pps_divider_bank_if.slave bus
);
    localparam int TW = (PH_W > WD_W) ? PH_W : WD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        HIGH  = 2'd3
    } state_t;

    logic            sync_p0, sync_p1, sync_p2, pps_e;
    logic [N_CH-1:0] pps_div, busy, overrun;

    // Stage boundary: 2-FF synchroniser (p0,p1), edge history (p2), registered edge strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            pps_e   <= 1'b0;
        end else begin
            sync_p0 <= bus.i_pps;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            pps_e   <= sync_p1 & ~sync_p2;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t           state, state_n;
        logic [DIV_W-1:0] pcnt, pcnt_n, div_q, div_in;
        logic [PH_W-1:0]  ph_q;
        logic [WD_W-1:0]  wd_q;
        logic             per_q;
        logic [TW-1:0]    tcnt, tcnt_n;
        logic             ovr_q, ovr_n, out_q, out_n, cfg_ld;

        assign div_in = bus.i_div_num[k*DIV_W +: DIV_W];

        // Config is a snapshot taken at start; it is don't-care until the first start.
        always_ff @(posedge i_clk) begin
            if (cfg_ld) begin
                div_q <= (div_in == '0) ? DIV_W'(1) : div_in;
                ph_q  <= bus.i_phase[k*PH_W +: PH_W];
                wd_q  <= bus.i_width[k*WD_W +: WD_W];
                per_q <= bus.i_per_true[k];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state <= IDLE;
                pcnt  <= '0;
                tcnt  <= '0;
                ovr_q <= 1'b0;
                out_q <= 1'b0;
            end else begin
                state <= state_n;
                pcnt  <= pcnt_n;
                tcnt  <= tcnt_n;
                ovr_q <= ovr_n;
                out_q <= out_n;
            end
        end

        always_comb begin
            state_n = state;
            pcnt_n  = pcnt;
            tcnt_n  = tcnt;
            ovr_n   = ovr_q;
            cfg_ld  = 1'b0;

            if (bus.i_stop[k]) begin
                state_n = IDLE;
                tcnt_n  = '0;
            end else if (bus.i_start[k]) begin
                cfg_ld  = 1'b1;
                state_n = ARMED;
                pcnt_n  = '0;
                tcnt_n  = '0;
                ovr_n   = 1'b0;
            end else begin
                // Edge counting runs in every non-idle state so the cadence survives a busy pulse.
                if (pps_e && (state != IDLE)) begin
                    if (pcnt == '0) begin
                        pcnt_n = div_q - DIV_W'(1);
                        if (state != ARMED) ovr_n = 1'b1;
                    end else begin
                        pcnt_n = pcnt - DIV_W'(1);
                    end
                end

                case (state)
                    ARMED: begin
                        if (pps_e && (pcnt == '0)) begin
                            if (ph_q == '0) begin
                                state_n = HIGH;
                                tcnt_n  = TW'(wd_q);
                            end else begin
                                state_n = DELAY;
                                tcnt_n  = TW'(ph_q);
                            end
                        end
                    end
                    DELAY: begin
                        if (tcnt <= TW'(1)) begin
                            state_n = HIGH;
                            tcnt_n  = TW'(wd_q);
                        end else begin
                            tcnt_n = tcnt - TW'(1);
                        end
                    end
                    HIGH: begin
                        // A zero width still spends one cycle here so busy/exit timing stays uniform.
                        if (tcnt <= TW'(1)) begin
                            state_n = per_q ? ARMED : IDLE;
                            tcnt_n  = '0;
                        end else begin
                            tcnt_n = tcnt - TW'(1);
                        end
                    end
                    default: ;
                endcase
            end

            out_n = (state_n == HIGH) && (tcnt_n != '0);
        end

        assign pps_div[k] = out_q;
        assign busy[k]    = (state != IDLE);
        assign overrun[k] = ovr_q;
    end

    assign bus.o_pps_div = pps_div;
    assign bus.o_busy    = busy;
    assign bus.o_overrun = overrun;
endmodule

// File: tb/tb_pps_divider_bank.sv
// Randomised and directed bench for pps_divider_bank: an edge-level reference model
// queues expected pulses, and an output monitor pops and compares them.
`timescale 1ns/1ps
module tb_pps_divider_bank;
    localparam int N_CH  = 4;
    localparam int DIV_W = 8;
    localparam int PH_W  = 32;
    localparam int WD_W  = 8;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    int   cyc     = 0;
    int   vectors = 0;
    int   errors  = 0;

    pps_divider_bank_if #(.N_CH(N_CH), .DIV_W(DIV_W), .PH_W(PH_W), .WD_W(WD_W)) bus ();

    pps_divider_bank #(.N_CH(N_CH), .DIV_W(DIV_W), .PH_W(PH_W), .WD_W(WD_W)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #50 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference model: per-channel latched config, edges seen since arming, end of in-flight pulse.
    pulse_t exp_q [N_CH][$];
    int     m_d [N_CH], m_p [N_CH], m_w [N_CH], m_cnt [N_CH], m_last [N_CH];
    bit     m_per [N_CH], m_armed [N_CH], m_done [N_CH], m_ovr [N_CH];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_until(input int n);
        if (cyc > n) begin
            vectors++;
            errors++;
            $display("FAIL wait_until: got cycle %0d expected at most %0d", cyc, n);
        end
        while (cyc < n) @(negedge i_clk);
    endtask

    // Cut short a pulse that a stop/start at cycle s forces low from cycle s+1.
    task automatic truncate(input int ch, input int s);
        pulse_t b;
        int     n;
        n = exp_q[ch].size();
        if (n > 0) begin
            b = exp_q[ch][n-1];
            if (b.start + b.width - 1 >= s + 1) begin
                b.width = s + 1 - b.start;
                if (b.width <= 0) void'(exp_q[ch].pop_back());
                else exp_q[ch][n-1] = b;
            end
        end
    endtask

    task automatic model_start(input int ch, input int d, input int p, input int w, input bit per);
        truncate(ch, cyc);
        m_d[ch]     = (d < 1) ? 1 : d;
        m_p[ch]     = p;
        m_w[ch]     = w;
        m_per[ch]   = per;
        m_armed[ch] = 1'b1;
        m_done[ch]  = 1'b0;
        m_cnt[ch]   = 0;
        m_last[ch]  = -1;
        m_ovr[ch]   = 1'b0;
    endtask

    task automatic model_stop(input int ch);
        truncate(ch, cyc);
        m_armed[ch] = 1'b0;
        m_last[ch]  = -1;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            exp_q[ch].delete();
            m_armed[ch] = 1'b0;
            m_done[ch]  = 1'b0;
            m_ovr[ch]   = 1'b0;
            m_last[ch]  = -1;
        end
    endtask

    // Edge e is the cycle in which the internal edge strobe is high.
    task automatic model_edge(input int e);
        pulse_t pp;
        int     k;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!m_armed[ch]) continue;
            if (m_done[ch] && e > m_last[ch]) continue;
            k = m_cnt[ch];
            m_cnt[ch]++;
            if (k % m_d[ch] != 0) continue;
            if (e <= m_last[ch]) begin
                m_ovr[ch] = 1'b1;
                continue;
            end
            m_last[ch] = e + m_p[ch] + ((m_w[ch] > 0) ? m_w[ch] : 1);
            if (m_w[ch] > 0) begin
                pp.start = e + 1 + m_p[ch];
                pp.width = m_w[ch];
                exp_q[ch].push_back(pp);
            end
            if (!m_per[ch]) m_done[ch] = 1'b1;
        end
    endtask

    function automatic bit exp_busy(input int ch, input int n);
        return m_armed[ch] && !(m_done[ch] && n > m_last[ch]);
    endfunction

    task automatic set_cfg(input int ch, input int d, input int p, input int w, input bit per);
        bus.i_div_num[ch*DIV_W +: DIV_W] = DIV_W'(d);
        bus.i_phase[ch*PH_W +: PH_W]     = PH_W'(p);
        bus.i_width[ch*WD_W +: WD_W]     = WD_W'(w);
        bus.i_per_true[ch]               = per;
    endtask

    task automatic arm(input int ch, input int d, input int p, input int w, input bit per);
        set_cfg(ch, d, p, w, per);
        bus.i_start[ch] = 1'b1;
        model_start(ch, d, p, w, per);
    endtask

    task automatic halt(input int ch);
        bus.i_stop[ch] = 1'b1;
        model_stop(ch);
    endtask

    task automatic strobe();
        tick(1);
        bus.i_start = '0;
        bus.i_stop  = '0;
    endtask

    task automatic pps_edge(input int hold, output int e);
        bus.i_pps = 1'b1;
        e = cyc + 3;
        model_edge(e);
        tick(hold);
        bus.i_pps = 1'b0;
    endtask

    task automatic check_pulse(input int ch, input int s, input int w);
        pulse_t x;
        vectors++;
        if (exp_q[ch].size() == 0) begin
            errors++;
            $display("FAIL pulse_ch%0d: got start %0d width %0d, expected no pulse", ch, s, w);
        end else begin
            x = exp_q[ch].pop_front();
            if (x.start != s || x.width != w) begin
                errors++;
                $display("FAIL pulse_ch%0d: got start %0d width %0d, expected start %0d width %0d",
                         ch, s, w, x.start, x.width);
            end
        end
    endtask

    bit prev_out [N_CH];
    int pulse_st [N_CH];

    always @(negedge i_clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!i_rst_n) begin
                prev_out[ch] = 1'b0;
            end else begin
                if (bus.o_pps_div[ch] && !prev_out[ch]) pulse_st[ch] = cyc;
                else if (!bus.o_pps_div[ch] && prev_out[ch]) check_pulse(ch, pulse_st[ch], cyc - pulse_st[ch]);
                prev_out[ch] = bus.o_pps_div[ch];
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got cycle %0d expected completion before time limit", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int e, e1, gap;
        bus.i_pps      = 1'b0;
        bus.i_start    = '0;
        bus.i_stop     = '0;
        bus.i_per_true = '0;
        bus.i_div_num  = '0;
        bus.i_phase    = '0;
        bus.i_width    = '0;
        model_reset();

        #10 i_rst_n = 1'b0;
        #20;
        chk("reset_out", bus.o_pps_div, 0);
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_ovr", bus.o_overrun, 0);
        tick(3);
        i_rst_n = 1'b1;
        tick(3);

        // Divider ratios 1/2/4/8 with widths 20/40/80/160, nine edges.
        for (int c = 0; c < N_CH; c++) arm(c, 1 << c, 0, 20 << c, 1'b1);
        strobe();
        chk("busy_after_start", bus.o_busy, 4'hf);
        tick(5);
        for (int i = 0; i < 9; i++) begin
            pps_edge(4, e);
            tick(396);
        end
        chk("ratio_ovr", bus.o_overrun, 0);
        for (int c = 0; c < N_CH; c++) halt(c);
        strobe();
        chk("ratio_stop_busy", bus.o_busy, 0);

        // One-shot with long phase; second edge after the pulse is ignored.
        arm(0, 1, 1000, 5, 1'b0);
        strobe();
        tick(10);
        pps_edge(4, e);
        wait_until(e + 1001);
        chk("oneshot_first_high", bus.o_pps_div[0], 1);
        wait_until(e + 1005);
        chk("oneshot_busy_hold", bus.o_busy[0], 1);
        wait_until(e + 1006);
        chk("oneshot_busy_fall", bus.o_busy[0], 0);
        tick(190);
        pps_edge(4, e);
        tick(1200);
        chk("oneshot_idle", bus.o_busy[0], 0);
        chk("oneshot_ovr", bus.o_overrun[0], 0);

        // Overrun: edges 50 cycles apart against a 70-cycle pulse.
        arm(1, 1, 30, 40, 1'b1);
        strobe();
        tick(5);
        for (int i = 0; i < 3; i++) begin
            pps_edge(5, e);
            tick(45);
        end
        tick(200);
        chk("ovr_set", bus.o_overrun[1], 1);
        chk("ovr_model", bus.o_overrun[1], m_ovr[1]);
        arm(1, 1, 30, 40, 1'b1);
        strobe();
        chk("ovr_cleared_by_start", bus.o_overrun[1], 0);
        halt(1);
        strobe();

        // Stop and start together while HIGH: stop wins.
        arm(2, 1, 0, 100, 1'b1);
        strobe();
        tick(5);
        pps_edge(4, e);
        wait_until(e + 20);
        tick(1);
        set_cfg(2, 3, 0, 10, 1'b1);
        bus.i_start[2] = 1'b1;
        halt(2);
        strobe();
        chk("stopstart_out", bus.o_pps_div[2], 0);
        chk("stopstart_busy", bus.o_busy[2], 0);
        tick(50);
        arm(2, 3, 0, 10, 1'b1);
        strobe();
        tick(5);
        for (int i = 0; i < 4; i++) begin
            pps_edge(4, e);
            tick(96);
        end
        halt(2);
        strobe();

        // D=0 acts as D=1, W=0 one-shot cycles busy with no pulse, long-held PPS gives one edge.
        arm(3, 0, 0, 10, 1'b1);
        arm(1, 1, 0, 0, 1'b0);
        strobe();
        tick(5);
        bus.i_pps = 1'b1;
        e = cyc + 3;
        model_edge(e);
        wait_until(e + 1);
        chk("w0_busy_high", bus.o_busy[1], 1);
        chk("w0_no_pulse", bus.o_pps_div[1], 0);
        chk("d0_pulse", bus.o_pps_div[3], 1);
        wait_until(e + 2);
        chk("w0_busy_fall", bus.o_busy[1], 0);
        tick(3000);
        bus.i_pps = 1'b0;
        tick(300);
        for (int i = 0; i < 2; i++) begin
            pps_edge(3, e);
            tick(297);
        end
        halt(3);
        halt(1);
        strobe();

        // Randomised configurations and edge spacing, including overlapping edges.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N_CH; c++)
                arm(c, $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200),
                    $urandom_range(0, 100), 1'($urandom_range(0, 1)));
            strobe();
            tick(5 + $urandom_range(0, 20));
            for (int i = 0; i < 8; i++) begin
                gap = $urandom_range(150, 600);
                pps_edge($urandom_range(1, 20), e);
                tick(gap);
            end
            tick(400);
            for (int c = 0; c < N_CH; c++) begin
                chk($sformatf("rand%0d_ovr_ch%0d", r, c), bus.o_overrun[c], m_ovr[c]);
                chk($sformatf("rand%0d_busy_ch%0d", r, c), bus.o_busy[c], exp_busy(c, cyc));
            end
            for (int c = 0; c < N_CH; c++) halt(c);
            strobe();
            chk($sformatf("rand%0d_stop_busy", r), bus.o_busy, 0);
        end

        // Reset while ch0 is HIGH, then an edge must not produce a pulse.
        arm(0, 1, 0, 100, 1'b1);
        strobe();
        tick(3);
        pps_edge(4, e1);
        wait_until(e1 + 30);
        chk("pre_reset_out", bus.o_pps_div[0], 1);
        #2 i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrun_reset_out", bus.o_pps_div, 0);
        chk("midrun_reset_busy", bus.o_busy, 0);
        chk("midrun_reset_ovr", bus.o_overrun, 0);
        tick(2);
        i_rst_n = 1'b1;
        tick(5);
        pps_edge(4, e);
        tick(300);
        chk("post_reset_busy", bus.o_busy, 0);
        chk("post_reset_out", bus.o_pps_div, 0);

        for (int c = 0; c < N_CH; c++)
            chk($sformatf("leftover_pulses_ch%0d", c), exp_q[c].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
